// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter and pending-write scoreboard.
// Two writeback sources share the single RF write port. Decode gets a hazard
// flag for any operand whose write has not yet landed in the RF.
module rf_wb_arbiter #(
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    input  logic          wb0_valid,
    input  logic [AW-1:0] wb0_rd,
    input  logic [DW-1:0] wb0_data,
    output logic          wb0_ready,
    input  logic          wb1_valid,
    input  logic [AW-1:0] wb1_rd,
    input  logic [DW-1:0] wb1_data,
    output logic          wb1_ready,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          hazard,
    output logic          rf_wr,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd,
    output logic [AW:0]   pend_cnt,
    output logic          err
);

    localparam int unsigned CW = AW + 1;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic            last_grant;   // 0: source 0 won last, 1: source 1 won last
    logic            gnt0;
    logic            gnt1;
    logic            grant;
    logic [AW-1:0]   gnt_rd;
    logic [DW-1:0]   gnt_data;
    logic            gnt_wr;
    logic            iss_set;
    logic            rs1_dep;
    logic            rs2_dep;
    logic [CW-1:0]   cnt_nxt;
    logic            err_nxt;

    // Round-robin arbitration: a lone requester wins, a conflict goes to the
    // source that did not win last.
    always_comb begin
        gnt0     = wb0_valid & (~wb1_valid | last_grant);
        gnt1     = wb1_valid & (~wb0_valid | ~last_grant);
        grant    = gnt0 | gnt1;
        gnt_rd   = gnt1 ? wb1_rd   : wb0_rd;
        gnt_data = gnt1 ? wb1_data : wb0_data;
        gnt_wr   = grant & (gnt_rd != '0);
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;

    // Issue is refused while its destination still has a write outstanding.
    always_comb begin
        iss_ready = ~pending[iss_rd] | (iss_rd == '0);
        iss_set   = iss_valid & iss_ready & (iss_rd != '0);
    end

    // Operand hazard: pending in the scoreboard, or being written right now
    // (the RF commits on the negedge of the rf_wr cycle).
    always_comb begin
        rs1_dep = (rs1 != '0) & (pending[rs1] | (rf_wr & (rf_a3 == rs1)));
        rs2_dep = (rs2 != '0) & (pending[rs2] | (rf_wr & (rf_a3 == rs2)));
        hazard  = rs1_dep | rs2_dep;
    end

    // Next scoreboard contents; a set on the same register overrides a clear.
    always_comb begin
        pending_nxt = pending;
        if (grant) begin
            pending_nxt[gnt_rd] = 1'b0;
        end
        if (iss_set) begin
            pending_nxt[iss_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Population count of the next scoreboard so pend_cnt tracks pending.
    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + CW'(pending_nxt[i]);
        end
    end

    // Protocol errors: write to a register nobody issued, or both sources
    // targeting the same nonzero register at once.
    always_comb begin
        err_nxt = err;
        if (gnt_wr && !pending[gnt_rd]) begin
            err_nxt = 1'b1;
        end
        if (wb0_valid && wb1_valid && (wb0_rd == wb1_rd) && (wb0_rd != '0)) begin
            err_nxt = 1'b1;
        end
    end

    // Scoreboard, arbitration history and error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            pend_cnt   <= '0;
            last_grant <= 1'b1;
            err        <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= cnt_nxt;
            err      <= err_nxt;
            if (grant) begin
                last_grant <= gnt1;
            end
        end
    end

    // Registered RF write port; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            rf_wr <= gnt_wr;
            if (gnt_wr) begin
                rf_a3 <= gnt_rd;
                rf_wd <= gnt_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// checked against a set-of-pending-registers model and an RF-write queue.
module tb_rf_wb_arbiter;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_ready;
    logic          wb0_valid;
    logic [AW-1:0] wb0_rd;
    logic [DW-1:0] wb0_data;
    logic          wb0_ready;
    logic          wb1_valid;
    logic [AW-1:0] wb1_rd;
    logic [DW-1:0] wb1_data;
    logic          wb1_ready;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          hazard;
    logic          rf_wr;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;
    logic [AW:0]   pend_cnt;
    logic          err;

    rf_wb_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .pend_cnt(pend_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which registers await a write, who won the last
    // conflict, what is on the RF port now, and the sticky error.
    bit m_pend [NREG];
    int m_last;
    bit m_err;
    bit m_wr_prev;
    int m_a3_prev;
    bit m_valid = 1'b0;
    bit m_g0, m_g1, m_iss_acc;
    int edge_n = 0;

    typedef struct {
        int          due;
        int          rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [AW-1:0] r);
        return (r != 0) && (m_pend[r] || (m_wr_prev && (m_a3_prev == int'(r))));
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_last    = 1;
        m_err     = 1'b0;
        m_wr_prev = 1'b0;
        m_a3_prev = 0;
    endtask

    // Model checker: predict combinational outputs, compare, then advance.
    always @(negedge clk) begin
        bit          e_iss, e_g0, e_g1, e_haz, gv;
        int          grd;
        logic [31:0] gdata;
        if (!m_valid) begin
            if (rst) begin
                model_reset();
                m_valid = 1'b1;
            end
        end else begin
            e_iss = (iss_rd == 0) || !m_pend[iss_rd];
            if (wb0_valid && wb1_valid) begin
                e_g0 = (m_last == 1);
                e_g1 = !e_g0;
            end else begin
                e_g0 = wb0_valid;
                e_g1 = wb1_valid;
            end
            e_haz = dep(rs1) || dep(rs2);
            chk("iss_ready", 64'(iss_ready), 64'(e_iss));
            chk("wb0_ready", 64'(wb0_ready), 64'(e_g0));
            chk("wb1_ready", 64'(wb1_ready), 64'(e_g1));
            chk("hazard",    64'(hazard),    64'(e_haz));
            chk("pend_cnt",  64'(pend_cnt),  64'(model_cnt()));
            chk("err",       64'(err),       64'(m_err));
            if (rst) begin
                m_iss_acc = 1'b0;
                m_g0      = 1'b0;
                m_g1      = 1'b0;
                model_reset();
            end else begin
                m_iss_acc = iss_valid && e_iss;
                m_g0      = e_g0;
                m_g1      = e_g1;
                gv        = e_g0 || e_g1;
                grd       = e_g1 ? int'(wb1_rd) : int'(wb0_rd);
                gdata     = e_g1 ? wb1_data : wb0_data;
                if (wb0_valid && wb1_valid && wb0_rd == wb1_rd && wb0_rd != 0) m_err = 1'b1;
                if (gv && grd != 0 && !m_pend[grd]) m_err = 1'b1;
                if (gv) begin
                    m_last = e_g1 ? 1 : 0;
                    if (grd != 0) m_pend[grd] = 1'b0;
                end
                if (m_iss_acc && iss_rd != 0) m_pend[iss_rd] = 1'b1;
                m_wr_prev = gv && grd != 0;
                if (m_wr_prev) begin
                    m_a3_prev = grd;
                    exp_q.push_back('{due: edge_n + 1, rd: grd, data: gdata});
                end
            end
        end
    end

    // RF-port monitor: each write must appear exactly on its due edge.
    always @(posedge clk) begin
        wr_t e;
        edge_n++;
        #2;
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            e = exp_q.pop_front();
            chk("rf_wr", 64'(rf_wr), 64'd1);
            chk("rf_a3", 64'(rf_a3), 64'(e.rd));
            chk("rf_wd", 64'(rf_wd), 64'(e.data));
        end else if (m_valid) begin
            chk("rf_wr_idle", 64'(rf_wr), 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic issue(input int rd);
        bit done = 1'b0;
        iss_valid = 1'b1;
        iss_rd    = AW'(rd);
        for (int i = 0; i < 64 && !done; i++) begin
            cyc();
            done = m_iss_acc;
        end
        iss_valid = 1'b0;
        if (!done) timeout("issue");
    endtask

    task automatic wb(input int src, input int rd, input logic [31:0] d);
        bit done = 1'b0;
        if (src == 0) begin wb0_valid = 1'b1; wb0_rd = AW'(rd); wb0_data = d; end
        else          begin wb1_valid = 1'b1; wb1_rd = AW'(rd); wb1_data = d; end
        for (int i = 0; i < 64 && !done; i++) begin
            cyc();
            done = (src == 0) ? m_g0 : m_g1;
        end
        if (src == 0) wb0_valid = 1'b0; else wb1_valid = 1'b0;
        if (!done) timeout("wb");
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Present both sources together and wait for both to be granted.
    task automatic wb_pair(input int rd0, input int rd1);
        bit done = 1'b0;
        wb0_valid = 1'b1; wb0_rd = AW'(rd0); wb0_data = $urandom;
        wb1_valid = 1'b1; wb1_rd = AW'(rd1); wb1_data = $urandom;
        for (int i = 0; i < 64 && !done; i++) begin
            cyc();
            if (m_g0) wb0_valid = 1'b0;
            if (m_g1) wb1_valid = 1'b0;
            done = !wb0_valid && !wb1_valid;
        end
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        if (!done) timeout("wb_pair");
    endtask

    int avail[$];

    task automatic pick(input int src);
        int idx;
        int rd;
        if ($urandom_range(0, 7) == 0) rd = 0;
        else if (avail.size() > 0) begin
            idx = int'($urandom_range(0, avail.size() - 1));
            rd  = avail[idx];
            avail.delete(idx);
        end else return;
        if (src == 0) begin wb0_valid = 1'b1; wb0_rd = AW'(rd); wb0_data = $urandom; end
        else          begin wb1_valid = 1'b1; wb1_rd = AW'(rd); wb1_data = $urandom; end
    endtask

    initial begin
        int  hold;
        bit  done;
        rst = 1'b1;
        iss_valid = 1'b0; iss_rd = '0;
        wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
        rs1 = AW'(5); rs2 = AW'(5);
        repeat (3) cyc();
        rst = 1'b0;

        // Idle after reset: every destination is free, nothing hazards.
        for (int i = 0; i < 4; i++) begin
            iss_rd = AW'($urandom_range(0, 31));
            cyc();
        end

        // Single issue and ALU writeback of rd=5 with rs1 watching it.
        issue(5);
        repeat (2) cyc();
        wb(0, 5, 32'hDEADBEEF);
        repeat (3) cyc();

        // Conflict after reset: source 0 first, then source 1.
        reset_pulse();
        issue(3);
        issue(4);
        rs1 = AW'(3); rs2 = AW'(4);
        wb_pair(3, 4);
        repeat (2) cyc();

        // WAW: the reissue of rd=7 stalls until its writeback is granted.
        issue(7);
        iss_valid = 1'b1; iss_rd = AW'(7);
        repeat (3) cyc();
        wb0_valid = 1'b1; wb0_rd = AW'(7); wb0_data = 32'h0000_0777;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            cyc();
            if (m_g0) wb0_valid = 1'b0;
            if (m_iss_acc) iss_valid = 1'b0;
            done = !wb0_valid && !iss_valid;
        end
        if (!done) timeout("waw");
        repeat (2) cyc();
        wb(1, 7, 32'h0000_7777);

        // x0 write is swallowed; a write to unissued rd=9 raises err.
        wb(1, 0, 32'h1234_5678);
        repeat (2) cyc();
        wb(0, 9, 32'h0000_0009);
        repeat (4) cyc();

        // Reset mid-operation with writes pending and a request in flight.
        issue(2);
        issue(6);
        wb0_valid = 1'b1; wb0_rd = AW'(2); wb0_data = 32'h2222_2222;
        rs1 = AW'(2); rs2 = AW'(6);
        reset_pulse();
        wb0_valid = 1'b0;
        cyc();
        issue(2);
        issue(6);
        wb_pair(2, 6);
        repeat (2) cyc();

        // Random traffic with legal writebacks only.
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            cyc();
            if (iss_valid && m_iss_acc) begin
                if (iss_rd != 0) avail.push_back(int'(iss_rd));
                iss_valid = 1'b0;
            end
            if (wb0_valid && m_g0) wb0_valid = 1'b0;
            if (wb1_valid && m_g1) wb1_valid = 1'b0;
            if (iss_valid) begin
                hold++;
                if (hold > 40) iss_valid = 1'b0;
            end
            if (!iss_valid && $urandom_range(0, 1) == 1) begin
                iss_valid = 1'b1;
                iss_rd    = AW'($urandom_range(0, 31));
                hold      = 0;
            end
            if (!wb0_valid && $urandom_range(0, 2) != 0) pick(0);
            if (!wb1_valid && $urandom_range(0, 2) != 0) pick(1);
            rs1 = AW'($urandom_range(0, 31));
            rs2 = AW'($urandom_range(0, 31));
        end

        // Drain every outstanding write.
        iss_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            cyc();
            if (wb0_valid && m_g0) wb0_valid = 1'b0;
            if (wb1_valid && m_g1) wb1_valid = 1'b0;
            if (!wb0_valid && avail.size() > 0) pick(0);
            if (!wb1_valid && avail.size() > 0) pick(1);
            done = avail.size() == 0 && !wb0_valid && !wb1_valid;
        end
        if (!done) timeout("drain");
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        repeat (3) cyc();
        chk("final_pend_cnt", 64'(pend_cnt), 64'd0);
        chk("final_err", 64'(err), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
